// File: rtl/mu0_cpu.sv
// MU0 16-bit accumulator CPU: two-cycle fetch/execute over a single shared memory bus.
// Memory is external; the bus outputs are combinational from the current state and IR.
module mu0_cpu #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_address,
  output logic              memrq,
  output logic              rnw
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STO = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JGE = 4'd5;
  localparam logic [3:0] OP_JNE = 4'd6;
  localparam logic [3:0] OP_STP = 4'd7;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] ir;
  logic [1:0]        state;

  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic              is_mem_op;

  assign op        = ir[DATA_W-1:DATA_W-4];
  assign operand   = ir[ADDR_W-1:0];
  // Opcodes 0-3 are exactly the ones that touch memory in EXEC.
  assign is_mem_op = (op[3:2] == 2'b00);
  assign out_data  = acc;

  // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
  always_comb begin
    out_address = pc;
    memrq       = 1'b0;
    rnw         = 1'b1;
    if (!rst_n) begin
      if (state == FETCH) begin
        memrq = 1'b1;
      end else if (state == EXEC && is_mem_op) begin
        out_address = operand;
        memrq       = 1'b1;
        rnw         = (op != OP_STO);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
      state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          ir    <= in_data;
          pc    <= pc + ADDR_W'(1);
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (op)
            OP_LDA: acc <= in_data;
            OP_ADD: acc <= acc + in_data;
            OP_SUB: acc <= acc - in_data;
            OP_JMP: pc  <= operand;
            OP_JGE: if (!acc[DATA_W-1]) pc <= operand;
            OP_JNE: if (acc != '0) pc <= operand;
            OP_STP: state <= HALT;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_cpu.sv
// Bench for mu0_cpu: an instruction-level MU0 model produces the expected bus trace,
// which is compared against the DUT every cycle, plus hand-computed spot checks.
module tb_mu0_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [15:0] out_data;
  logic [11:0] out_address;
  logic        memrq;
  logic        rnw;

  mu0_cpu #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .out_data    (out_data),
    .out_address (out_address),
    .memrq       (memrq),
    .rnw         (rnw)
  );

  always #5 clk = ~clk;

  // External 32x16 memory: combinational read, write on the rising edge.
  logic [15:0] mem [32];
  logic [15:0] img [32];
  logic        load_req;

  assign in_data = mem[out_address[4:0]];

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 32; i++) mem[i] <= img[i];
    end else if (memrq && !rnw) begin
      mem[out_address[4:0]] <= out_data;
    end
  end

  // Expected bus cycle; wr marks a store the model applies once that cycle is consumed.
  typedef struct packed {
    logic [11:0] addr;
    logic        memrq;
    logic        rnw;
    logic [15:0] data;
    logic        wr;
  } bus_t;

  bus_t        q[$];
  logic [15:0] mm [32];
  logic [11:0] m_pc;
  logic [15:0] m_acc;
  logic        m_halt;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] obs_addr;
  logic        obs_memrq;
  logic        obs_rnw;
  logic [15:0] obs_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bus_t ent(input logic [11:0] a, input logic r, input logic w, input logic wr);
    bus_t e;
    e.addr  = a;
    e.memrq = r;
    e.rnw   = w;
    e.data  = m_acc;
    e.wr    = wr;
    return e;
  endfunction

  // Executes one whole instruction, queueing its fetch and execute bus cycles.
  task automatic model_instr();
    logic [15:0] inst;
    logic [11:0] s;
    if (m_halt) begin
      q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0));
      return;
    end
    inst = mm[m_pc[4:0]];
    q.push_back(ent(m_pc, 1'b1, 1'b1, 1'b0));
    m_pc = m_pc + 12'd1;
    s = inst[11:0];
    case (inst[15:12])
      4'd0: begin q.push_back(ent(s, 1'b1, 1'b1, 1'b0)); m_acc = mm[s[4:0]]; end
      4'd1: q.push_back(ent(s, 1'b1, 1'b0, 1'b1));
      4'd2: begin q.push_back(ent(s, 1'b1, 1'b1, 1'b0)); m_acc = m_acc + mm[s[4:0]]; end
      4'd3: begin q.push_back(ent(s, 1'b1, 1'b1, 1'b0)); m_acc = m_acc - mm[s[4:0]]; end
      4'd4: begin q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0)); m_pc = s; end
      4'd5: begin q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0)); if (!m_acc[15]) m_pc = s; end
      4'd6: begin q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0)); if (m_acc != 16'd0) m_pc = s; end
      4'd7: begin q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0)); m_halt = 1'b1; end
      default: q.push_back(ent(m_pc, 1'b0, 1'b1, 1'b0));
    endcase
  endtask

  // One clock cycle: sample at the falling edge, compare with the model, advance.
  task automatic step();
    bus_t e;
    if (q.size() == 0) model_instr();
    e = q.pop_front();
    @(negedge clk);
    obs_addr  = out_address;
    obs_memrq = memrq;
    obs_rnw   = rnw;
    obs_data  = out_data;
    check("bus_addr", obs_addr, e.addr);
    check("bus_memrq", obs_memrq, e.memrq);
    check("bus_rnw", obs_rnw, e.rnw);
    check("bus_out_data", obs_data, e.data);
    if (e.wr) mm[e.addr[4:0]] = e.data;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = 12'd0;
    m_acc  = 16'd0;
    m_halt = 1'b0;
  endtask

  task automatic clear_img();
    for (int i = 0; i < 32; i++) img[i] = 16'h0000;
  endtask

  // Two reset cycles (memory image loaded during the first), then release.
  task automatic start_test();
    rst_n    = 1'b1;
    load_req = 1'b1;
    for (int i = 0; i < 32; i++) mm[i] = img[i];
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset_memrq", memrq, 1'b0);
      check("reset_rnw", rnw, 1'b1);
      @(posedge clk);
      #1;
      load_req = 1'b0;
    end
    rst_n = 1'b0;
    model_reset();
  endtask

  task automatic run_program(input int budget);
    int n = 0;
    while (!(m_halt && q.size() == 0) && n < budget) begin
      step();
      n++;
    end
    check("halt_within_budget", (n < budget), 1'b1);
    repeat (4) step();
  endtask

  int          jc [6] = '{4, 8, 12, 16, 20, 22};
  logic [11:0] ja [6] = '{12'd2, 12'd6, 12'd8, 12'd11, 12'd14, 12'd15};

  initial begin
    rst_n    = 1'b1;
    load_req = 1'b0;

    // LDA/STO and reset release.
    clear_img();
    img[0] = 16'h0013; img[1] = 16'h1012; img[2] = 16'h7000; img[19] = 16'h0002;
    start_test();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) begin
        check("first_fetch_addr", obs_addr, 12'd0);
        check("first_fetch_memrq", obs_memrq, 1'b1);
        check("first_fetch_rnw", obs_rnw, 1'b1);
      end
      if (i == 1) check("lda_read_addr", obs_addr, 12'd19);
      if (i == 3) begin
        check("sto_addr", obs_addr, 12'd18);
        check("sto_rnw", obs_rnw, 1'b0);
        check("sto_data", obs_data, 16'h0002);
      end
    end
    check("sto_mem18", mem[18], 16'h0002);

    // ADD wrap to 0, SUB wrap to 0xFFFF.
    clear_img();
    img[0] = 16'h0010; img[1] = 16'h2011; img[2] = 16'h1012;
    img[3] = 16'h3011; img[4] = 16'h1013; img[5] = 16'h7000;
    img[16] = 16'hFFFF; img[17] = 16'h0001; img[18] = 16'h1234; img[19] = 16'h1234;
    start_test();
    run_program(100);
    check("add_wrap_mem18", mem[18], 16'h0000);
    check("sub_wrap_mem19", mem[19], 16'hFFFF);

    // Jumps: JNE fall/taken, JGE fall on negative, JGE taken on zero, NOP, JMP.
    clear_img();
    img[0] = 16'h0010; img[1] = 16'h6005; img[2] = 16'h0011; img[3] = 16'h6006;
    img[4] = 16'h7000; img[5] = 16'h7000; img[6] = 16'h0012; img[7] = 16'h5004;
    img[8] = 16'h0010; img[9] = 16'h500B; img[10] = 16'h7000; img[11] = 16'h8123;
    img[12] = 16'h400E; img[13] = 16'h7000; img[14] = 16'h7000;
    img[16] = 16'h0000; img[17] = 16'h0005; img[18] = 16'h8000;
    start_test();
    for (int i = 0; i < 26; i++) begin
      step();
      for (int k = 0; k < 6; k++)
        if (i == jc[k]) check($sformatf("jump_fetch_c%0d", i), obs_addr, ja[k]);
    end

    // PC wrap: JMP 0xFFF, fetch from 0xFFF, then PC rolls to 0.
    clear_img();
    img[0] = 16'h4FFF; img[31] = 16'h8000;
    start_test();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 2) check("fetch_fff", obs_addr, 12'hFFF);
      if (i == 4) check("pc_wrap_fetch0", obs_addr, 12'h000);
    end

    // Summation program.
    clear_img();
    img[0]  = 16'h0013; img[1]  = 16'h1012; img[2]  = 16'h1011; img[3]  = 16'h3010;
    img[4]  = 16'h6006; img[5]  = 16'h7000; img[6]  = 16'h0011; img[7]  = 16'h2014;
    img[8]  = 16'h1011; img[9]  = 16'h2012; img[10] = 16'h1012; img[11] = 16'h0011;
    img[12] = 16'h3010; img[13] = 16'h6006; img[14] = 16'h7000;
    img[16] = 16'h0012; img[17] = 16'h0000; img[18] = 16'h0000;
    img[19] = 16'h0002; img[20] = 16'h0001;
    start_test();
    run_program(1000);
    check("sum_mem18", mem[18], 16'h00AA);
    check("sum_mem17", mem[17], 16'h0012);
    check("sum_acc", obs_data, 16'h0000);
    check("halt_memrq", obs_memrq, 1'b0);
    for (int a = 16; a < 21; a++) check($sformatf("sum_model_mem%0d", a), mem[a], mm[a]);

    // Reset asserted during STO execute: no write, restart at PC 0.
    clear_img();
    img[0] = 16'h0013; img[1] = 16'h1012; img[19] = 16'h0002; img[18] = 16'h5555;
    start_test();
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    @(negedge clk);
    check("midsto_memrq", memrq, 1'b0);
    check("midsto_rnw", rnw, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    step();
    check("midsto_restart_addr", obs_addr, 12'd0);
    check("midsto_restart_memrq", obs_memrq, 1'b1);
    check("midsto_no_write", mem[18], 16'h5555);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
